// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, func3
// encodings and byte-enable patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replicated store data,
// size/alignment legality, and load byte/half extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_store,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_fault,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Access size comes from func3[1:0]; BU/HU share the B/H lane rules.
  always_comb begin
    o_be    = BE_NONE;
    o_wdata = 32'h0000_0000;
    o_fault = 1'b0;
    case (i_func3[1:0])
      2'b00: begin
        o_be    = BE_BYTE0 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
        o_wdata = {2{i_wdata[15:0]}};
        if (i_addr_lo[0]) o_fault = 1'b1;
        else              o_fault = 1'b0;
      end
      2'b10: begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        if (i_addr_lo != 2'b00) o_fault = 1'b1;
        else                    o_fault = 1'b0;
      end
      default: o_fault = 1'b1;
    endcase
    case (i_func3)
      F3_B, F3_H, F3_W: ;
      F3_BU, F3_HU: if (i_is_store) o_fault = 1'b1;
      default: o_fault = 1'b1;
    endcase
  end

  // Load extraction uses the latched address bits and func3.
  always_comb begin
    w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_func3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_W:    o_ldata = i_rdata;
      F3_BU:   o_ldata = {24'h00_0000, w_byte};
      F3_HU:   o_ldata = {16'h0000, w_half};
      default: o_ldata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: IDLE/REQ/DONE handshake with the data memory,
// request latching, core stall generation and a REQ-phase watchdog.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_func3;
  logic        r_mem_req, r_mem_we, r_load_valid, r_bus_err;
  logic [31:0] r_mem_addr, r_mem_wdata, r_load_data;
  logic [3:0]  r_mem_be;
  logic [3:0]  w_be;
  logic [31:0] w_st_data, w_ld_data;
  logic        w_size_fault, w_fault, w_valid, w_timeout, w_stall;

  lsu_align u_align (
    .i_func3      (func3),
    .i_addr_lo    (addr[1:0]),
    .i_is_store   (wr_en),
    .i_wdata      (wdata),
    .i_ld_func3   (r_func3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_st_data),
    .o_fault      (w_size_fault),
    .o_ldata      (w_ld_data)
  );

  assign w_fault   = (rd_en | wr_en) & ((rd_en & wr_en) | w_size_fault);
  assign w_valid   = (rd_en ^ wr_en) & ~w_size_fault;
  assign w_timeout = (r_cnt == CNT_W'(MAX_WAIT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and stall decode.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_valid;
        if (w_valid) w_next_state = ST_REQ;
        else         w_next_state = ST_IDLE;
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (mem_ready || w_timeout) w_next_state = ST_DONE;
        else                        w_next_state = ST_REQ;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latches, watchdog counter and write-back registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_addr_lo    <= 2'b00;
      r_func3      <= 3'b000;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_be     <= 4'b0000;
      r_load_data  <= 32'h0000_0000;
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_cnt       <= '0;
            r_addr_lo   <= addr[1:0];
            r_func3     <= func3;
            r_mem_req   <= 1'b1;
            r_mem_we    <= wr_en;
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_wdata <= wr_en ? w_st_data : 32'h0000_0000;
            r_mem_be    <= w_be;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_load_data  <= w_ld_data;
              r_load_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall        = rst_n & w_stall;
  assign access_fault = rst_n & (r_state == ST_IDLE) & w_fault;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;
  assign load_data    = r_load_data;
  assign load_valid   = r_load_valid;
  assign bus_err      = r_bus_err;

endmodule
